// File: rtl/hazard_load_multi_pkg.sv
// Shared types and limits for the load-use hazard unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: default register-specifier width, the deepest supported load
// latency, and the {valid, dst} record kept for every in-flight load.
package hazard_pkg;

    localparam int REG_W_DEFAULT = 3;
    localparam int MAX_LOAD_LAT  = 4;

    // One in-flight load: dst is the destination register, valid is set
    // only when the instruction really was a register-writing load.
    typedef struct packed {
        logic                     valid;
        logic [REG_W_DEFAULT-1:0] dst;
    } load_track_t;

endpackage

// File: rtl/hazard_load_multi_if.sv
// Bundle between the decode-stage hazard unit and the pipeline it controls.
// Latency: n/a (wires only).
// Backpressure: memBusy freezes the pipe; writePc/writeIfId hold the front end.
//
// modport slave  : the hazard unit (reads pipeline state, drives enables).
// modport master : the pipeline side (drives state, obeys enables).
// loadStallCycles/memStallCycles are only live with HAZARD_PERF_EN.
interface hazard_load_multi_if #(
    parameter int REG_W = hazard_pkg::REG_W_DEFAULT,
    parameter int CNT_W = 16
);
    // ID/EX producer
    logic             MemReadIdEx;
    logic [REG_W-1:0] writeRegIdEx;
    logic             writeRegValidIdEx;
    // IF/ID consumer
    logic [REG_W-1:0] RsIfId;
    logic [REG_W-1:0] RtIfId;
    logic             RsValidIfId;
    logic             RtValidIfId;
    // pipeline conditions
    logic             memBusy;
    logic             flushIfId;
    // controls back to the pipeline
    logic             writePc;
    logic             writeIfId;
    logic             controlZeroIdEx;
    logic             pipeFreeze;
    logic [CNT_W-1:0] loadStallCycles;
    logic [CNT_W-1:0] memStallCycles;

    modport slave (
        input  MemReadIdEx, writeRegIdEx, writeRegValidIdEx,
        input  RsIfId, RtIfId, RsValidIfId, RtValidIfId,
        input  memBusy, flushIfId,
        output writePc, writeIfId, controlZeroIdEx, pipeFreeze,
        output loadStallCycles, memStallCycles
    );

    modport master (
        output MemReadIdEx, writeRegIdEx, writeRegValidIdEx,
        output RsIfId, RtIfId, RsValidIfId, RtValidIfId,
        output memBusy, flushIfId,
        input  writePc, writeIfId, controlZeroIdEx, pipeFreeze,
        input  loadStallCycles, memStallCycles
    );

endinterface

// File: rtl/hazard_load_multi_load_track_pipe.sv
// Shift register of in-flight load records (slots 1..DEPTH past ID/EX).
// Latency: one clk per slot; slot index k holds the load k+1 cycles past ID/EX.
// Backpressure: hold=1 freezes every slot; no shifting, nothing dropped.
//
// Ports: clk, rst (sync, active high), hold, slot_in (record entering
// slot 1), slots[] (all stored records, exposed for comparison).
// DEPTH=0 builds no storage and returns a single all-invalid slot.
module load_track_pipe #(
    parameter type T     = hazard_pkg::load_track_t,
    parameter int  DEPTH = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    input  T     slot_in,
    output T     slots [(DEPTH > 0) ? DEPTH : 1]
);

    if (DEPTH == 0) begin : g_none
        assign slots[0] = '0;
        wire unused_in = ^{clk, rst, hold, slot_in};
    end else begin : g_pipe
        T slot_q [DEPTH];
        T slot_d [DEPTH];

        always_comb begin
            slot_d = slot_q;
            if (!hold) begin
                slot_d[0] = slot_in;
                for (int k = 1; k < DEPTH; k++) begin
                    slot_d[k] = slot_q[k-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < DEPTH; k++) begin
                    slot_q[k] <= '0;
                end
            end else begin
                slot_q <= slot_d;
            end
        end

        assign slots = slot_q;
    end

endmodule

// File: rtl/hazard_load_multi.sv
// Decode-stage load-use hazard unit for loads of 1..4 cycles latency.
// Latency: all controls are combinational from the current inputs (0 cycles).
// Backpressure: memBusy freezes the whole pipe; a hazard stalls PC/IF-ID only.
//
// Ports: clk, rst (sync, active high), hz (hazard_load_multi_if.slave).
// Optional macro HAZARD_PERF_EN builds saturating stall counters; without it
// loadStallCycles/memStallCycles read 0 and no counter flops exist.
module hazard_load_multi
    import hazard_pkg::*;
#(
    parameter int REG_W    = REG_W_DEFAULT,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_load_multi_if.slave  hz
);

    // An out-of-range latency fails elaboration on an undefined module.
    if (LOAD_LAT < 1 || LOAD_LAT > MAX_LOAD_LAT) begin : g_bad_load_lat
        illegal_load_lat_parameter u_bad ();
    end

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dst;
    } track_t;

    localparam int DEPTH = LOAD_LAT - 1;
    localparam int NSLOT = (DEPTH > 0) ? DEPTH : 1;

    track_t slot0;
    track_t slots [NSLOT];
    logic   any_match;
    logic   is_hazard;

    function automatic logic hits(input track_t t,
                                  input logic [REG_W-1:0] rs, input logic rs_v,
                                  input logic [REG_W-1:0] rt, input logic rt_v);
        return t.valid && ((t.dst == rs && rs_v) || (t.dst == rt && rt_v));
    endfunction

    // Slot 0 is the live ID/EX instruction; it is also what enters slot 1.
    // When a bubble is inserted the load itself still advances, so the
    // record is captured before ID/EX is zeroed.
    always_comb begin
        slot0.valid = hz.MemReadIdEx & hz.writeRegValidIdEx;
        slot0.dst   = hz.writeRegIdEx;
        any_match   = hits(slot0, hz.RsIfId, hz.RsValidIfId,
                           hz.RtIfId, hz.RtValidIfId);
        for (int k = 0; k < DEPTH; k++) begin
            any_match = any_match | hits(slots[k], hz.RsIfId, hz.RsValidIfId,
                                         hz.RtIfId, hz.RtValidIfId);
        end
        // A frozen pipe issues no bubble; the stall resumes when memBusy drops.
        is_hazard = any_match & ~hz.flushIfId & ~hz.memBusy;
    end

    load_track_pipe #(
        .T     (track_t),
        .DEPTH (DEPTH)
    ) u_track (
        .clk     (clk),
        .rst     (rst),
        .hold    (hz.memBusy),
        .slot_in (slot0),
        .slots   (slots)
    );

    // With LOAD_LAT=1 the stored slot is a constant and never compared.
    wire unused_slots = ^slots[0];

    assign hz.writePc         = ~(is_hazard | hz.memBusy);
    assign hz.writeIfId       = ~(is_hazard | hz.memBusy);
    assign hz.controlZeroIdEx = is_hazard;
    assign hz.pipeFreeze      = hz.memBusy;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0] mem_cnt_q,  mem_cnt_d;

    always_comb begin
        load_cnt_d = load_cnt_q;
        mem_cnt_d  = mem_cnt_q;
        if (is_hazard && !(&load_cnt_q)) begin
            load_cnt_d = load_cnt_q + CNT_W'(1);
        end
        if (hz.memBusy && !(&mem_cnt_q)) begin
            mem_cnt_d = mem_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_q <= '0;
            mem_cnt_q  <= '0;
        end else begin
            load_cnt_q <= load_cnt_d;
            mem_cnt_q  <= mem_cnt_d;
        end
    end

    assign hz.loadStallCycles = load_cnt_q;
    assign hz.memStallCycles  = mem_cnt_q;
`else
    assign hz.loadStallCycles = '0;
    assign hz.memStallCycles  = '0;
`endif

endmodule

// File: tb/tb_hazard_load_multi.sv
// Directed bench for hazard_load_multi: four instances (LOAD_LAT 1, 2, 3 and
// a LOAD_LAT 1 / CNT_W 4 instance for the counters), each driven cycle by
// cycle with the ID/EX and IF/ID contents a real pipeline would present.
module tb_hazard_load_multi;

    typedef struct packed {
        logic       mr;
        logic       wrv;
        logic [2:0] wr;
        logic       rsv;
        logic [2:0] rs;
        logic       rtv;
        logic [2:0] rt;
        logic       busy;
        logic       flush;
    } vec_t;

    // Expected {writePc, writeIfId, controlZeroIdEx, pipeFreeze}
    localparam logic [3:0] GO  = 4'b1100;
    localparam logic [3:0] BUB = 4'b0010;
    localparam logic [3:0] FRZ = 4'b0001;

`ifdef HAZARD_PERF_EN
    localparam logic [31:0] EXP_LS = 32'd1;
    localparam logic [31:0] EXP_MS = 32'd15;
`else
    localparam logic [31:0] EXP_LS = 32'd0;
    localparam logic [31:0] EXP_MS = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    vec_t        v [4];
    logic        o_wpc [4];
    logic        o_wif [4];
    logic        o_cz  [4];
    logic        o_fz  [4];
    logic [31:0] o_lsc [4];
    logic [31:0] o_msc [4];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int LAT = (g == 3) ? 1 : g + 1;
        localparam int CW  = (g == 3) ? 4 : 16;

        hazard_load_multi_if #(.REG_W(3), .CNT_W(CW)) ifc ();

        assign ifc.MemReadIdEx       = v[g].mr;
        assign ifc.writeRegValidIdEx = v[g].wrv;
        assign ifc.writeRegIdEx      = v[g].wr;
        assign ifc.RsValidIfId       = v[g].rsv;
        assign ifc.RsIfId            = v[g].rs;
        assign ifc.RtValidIfId       = v[g].rtv;
        assign ifc.RtIfId            = v[g].rt;
        assign ifc.memBusy           = v[g].busy;
        assign ifc.flushIfId         = v[g].flush;

        hazard_load_multi #(.REG_W(3), .LOAD_LAT(LAT), .CNT_W(CW)) u_dut (
            .clk (clk),
            .rst (rst),
            .hz  (ifc)
        );

        assign o_wpc[g] = ifc.writePc;
        assign o_wif[g] = ifc.writeIfId;
        assign o_cz[g]  = ifc.controlZeroIdEx;
        assign o_fz[g]  = ifc.pipeFreeze;
        assign o_lsc[g] = 32'(ifc.loadStallCycles);
        assign o_msc[g] = 32'(ifc.memStallCycles);
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Load in ID/EX writing wr_r; IF/ID reads rs_r on Rs.
    function automatic vec_t vld(input int wr_r, input int rs_r);
        vec_t x = '0;
        x.mr = 1'b1; x.wrv = 1'b1; x.wr = 3'(wr_r);
        x.rsv = 1'b1; x.rs = 3'(rs_r);
        return x;
    endfunction

    // Non-load ALU op in ID/EX writing wr_r; IF/ID reads rs_r.
    function automatic vec_t valu(input int wr_r, input int rs_r);
        vec_t x = vld(wr_r, rs_r);
        x.mr = 1'b0;
        return x;
    endfunction

    // Bubble in ID/EX; IF/ID (held) reads rs_r.
    function automatic vec_t vbub(input int rs_r);
        vec_t x = '0;
        x.rsv = 1'b1; x.rs = 3'(rs_r);
        return x;
    endfunction

    // Present one cycle of inputs, check the combinational controls mid-cycle,
    // then advance to just past the next rising edge.
    task automatic step(input int d, input vec_t vin, input logic [3:0] exp,
                        input string tag);
        v[d] = vin;
        #1;
        check_eq(tag, 32'({o_wpc[d], o_wif[d], o_cz[d], o_fz[d]}), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t t;
        for (int i = 0; i < 4; i++) v[i] = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        for (int d = 0; d < 4; d++) begin
            step(d, '0, GO, "rst_idle");
            check_eq("rst_lsc", o_lsc[d], 32'd0);
            check_eq("rst_msc", o_msc[d], 32'd0);
        end

        // LOAD_LAT=1
        step(0, vld(3, 3), BUB, "l1_use");
        step(0, vbub(3),   GO,  "l1_after");
        t = vld(4, 0); t.rtv = 1'b1; t.rt = 3'd4;
        step(0, t,         BUB, "l1_rt");
        step(0, vbub(0),   GO,  "l1_rt_after");
        t = vld(4, 0); t.rt = 3'd4;
        step(0, t,         GO,  "l1_rt_invalid");
        t = vld(2, 2); t.rtv = 1'b1; t.rt = 3'd2;
        step(0, t,         BUB, "l1_both");
        step(0, vbub(2),   GO,  "l1_both_after");
        t = vld(3, 3); t.wrv = 1'b0;
        step(0, t,         GO,  "l1_no_wr");
        step(0, vld(0, 0), BUB, "l1_r0");
        step(0, vbub(0),   GO,  "l1_r0_after");
        step(0, '0,        GO,  "l1_idle");

        // LOAD_LAT=2: adjacent consumer
        step(1, vld(3, 3), BUB, "l2_b1");
        step(1, vbub(3),   BUB, "l2_b2");
        step(1, vbub(3),   GO,  "l2_go");
        // one independent instruction between
        step(1, vld(3, 1), GO,  "l2_j1_a");
        step(1, valu(1, 3), BUB, "l2_j1_b");
        step(1, vbub(3),   GO,  "l2_j1_go");
        // two independent instructions between
        step(1, vld(3, 1), GO,  "l2_j2_a");
        step(1, valu(1, 2), GO, "l2_j2_b");
        step(1, valu(2, 3), GO, "l2_j2_c");
        // memBusy for three cycles in the middle of the stall
        step(1, vld(3, 3), BUB, "l2_busy_pre");
        t = vbub(3); t.busy = 1'b1;
        for (int i = 0; i < 3; i++) step(1, t, FRZ, "l2_busy");
        step(1, vbub(3),   BUB, "l2_resume");
        step(1, vbub(3),   GO,  "l2_resume_go");
        // memBusy with a slot-0 match suppresses the bubble
        t = vld(3, 3); t.busy = 1'b1;
        step(1, t,         FRZ, "l2_busy_s0");
        step(1, vld(3, 3), BUB, "l2_busy_s0_b1");
        step(1, vbub(3),   BUB, "l2_busy_s0_b2");
        step(1, vbub(3),   GO,  "l2_busy_s0_go");
        // flush: no bubble for the squashed consumer, slots still shift
        t = vld(5, 5); t.flush = 1'b1;
        step(1, t,         GO,  "l2_flush");
        step(1, vbub(5),   BUB, "l2_flush_shift");
        step(1, vbub(5),   GO,  "l2_flush_go");
        // non-load writing r5 never stalls
        step(1, valu(5, 5), GO, "l2_nonload");
        step(1, vbub(5),   GO,  "l2_nonload_after");
        step(1, '0,        GO,  "l2_idle");

        // LOAD_LAT=3
        step(2, vld(6, 6), BUB, "l3_b1");
        step(2, vbub(6),   BUB, "l3_b2");
        step(2, vbub(6),   BUB, "l3_b3");
        step(2, vbub(6),   GO,  "l3_go");
        step(2, vld(6, 1), GO,  "l3_j1_a");
        step(2, valu(1, 6), BUB, "l3_j1_b1");
        step(2, vbub(6),   BUB, "l3_j1_b2");
        step(2, vbub(6),   GO,  "l3_j1_go");
        // reset in the middle of a stall clears tracking
        step(2, vld(6, 6), BUB, "l3_rst_b1");
        step(2, vbub(6),   BUB, "l3_rst_b2");
        v[2] = vbub(6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(2, vbub(6),   GO,  "l3_rst_clear");
        check_eq("l3_rst_lsc", o_lsc[2], 32'd0);
        check_eq("l3_rst_msc", o_msc[2], 32'd0);
        step(2, '0,        GO,  "l3_idle");

        // Counters (CNT_W=4): one bubble, then 20 busy cycles
        step(3, vld(3, 3), BUB, "pf_bub");
        step(3, vbub(3),   GO,  "pf_go");
        check_eq("pf_load_cnt", o_lsc[3], EXP_LS);
        t = vbub(3); t.busy = 1'b1;
        for (int i = 0; i < 20; i++) step(3, t, FRZ, "pf_busy");
        check_eq("pf_mem_sat", o_msc[3], EXP_MS);
        check_eq("pf_load_hold", o_lsc[3], EXP_LS);
        v[3] = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("pf_rst_lsc", o_lsc[3], 32'd0);
        check_eq("pf_rst_msc", o_msc[3], 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_load_multi.md
Name: hazard_load_multi

Overview:
- Parametrised load-use hazard unit for the 5-stage pipeline. Supports load latencies of 1..4 cycles past EX, a data-memory busy freeze, and a branch flush.
- Keeps a shift register of in-flight load destinations, so a consumer in IF/ID gets exactly the bubbles it needs regardless of intervening instructions.
- Sits in decode. Drives PC/IF-ID write enables, the ID/EX control-zero mux and a global pipeline freeze.

Parameters:
- REG_W, 3, register-specifier width.
- LOAD_LAT, 1, number of stages (EX onward) in which a load result is not yet forwardable; legal 1..4, 1 = classic one-bubble load-use.
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- MemReadIdEx  in  1  instruction in ID/EX is a load.
- writeRegIdEx  in  REG_W  destination of ID/EX instruction.
- writeRegValidIdEx  in  1  ID/EX instruction writes a register.
- RsIfId, RtIfId  in  REG_W  source specifiers of IF/ID instruction.
- RsValidIfId, RtValidIfId  in  1  source actually read.
- memBusy  in  1  data memory not ready; whole pipeline must hold.
- flushIfId  in  1  IF/ID instruction is being squashed this cycle.
- writePc  out  1  PC write enable.
- writeIfId  out  1  IF/ID write enable.
- controlZeroIdEx  out  1  insert bubble into ID/EX.
- pipeFreeze  out  1  hold ID/EX, EX/MEM, MEM/WB.
- loadStallCycles  out  CNT_W  (optional feature) load-use bubble count.
- memStallCycles  out  CNT_W  (optional feature) memBusy cycle count.

Behaviour:
- Track slots 1..LOAD_LAT-1 each hold {valid, reg}. Slot 0 is the live ID/EX inputs (combinational). LOAD_LAT=1 means no storage.
- Slot 0 match: MemReadIdEx & writeRegValidIdEx & ((writeRegIdEx==RsIfId & RsValidIfId) | (writeRegIdEx==RtIfId & RtValidIfId)).
- Slot k match: valid[k] & same register compare against Rs/Rt with their valid bits.
- isHazard = any slot match & !flushIfId & !memBusy.
- Outputs:
  - writePc = writeIfId = !(isHazard | memBusy).
  - controlZeroIdEx = isHazard.
  - pipeFreeze = memBusy.
  - All outputs are combinational, with zero latency from inputs.
- Shift on each rising clk when !memBusy:
  - slot1 <= {MemReadIdEx & writeRegValidIdEx, writeRegIdEx};
  - slot k+1 <= slot k;
  - the last slot drops off.
  - A bubble inserted into ID/EX is not a load, so slot1 is loaded from the current ID/EX contents before they are zeroed. This is correct because the load itself advances.
- memBusy=1: all slots hold. No bubble is inserted; controlZeroIdEx=0 even if a match exists. The stall resumes the cycle memBusy drops.
- flushIfId=1: no bubble and no stall for the squashed instruction. Slots still shift normally.
- Bubble counts for a consumer in IF/ID:
  - Load immediately ahead: exactly LOAD_LAT bubbles.
  - Load j instructions ahead: max(0, LOAD_LAT-j) bubbles.
- Reset: all slot valid bits 0 and counters 0. With idle inputs after reset, writePc=1, writeIfId=1, controlZeroIdEx=0, pipeFreeze=0.
- Reset mid-stall clears all tracking. The next cycle evaluates only slot 0.
- Both Rs and Rt matching counts as one hazard. Register 0 gets no special treatment.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined: loadStallCycles increments on every cycle controlZeroIdEx=1, and memStallCycles increments on every cycle memBusy=1. Both saturate at all-ones, and both clear on rst.
- When undefined: the counter ports are tied to 0 and no counter flops are built.

Decomposition:
- Package hazard_pkg holds:
  - REG_W default;
  - MAX_LOAD_LAT=4;
  - typedef load_track_t {valid, reg}.
- One sub-module, load_track_pipe: the parametrised shift register of load_track_t with a hold enable. It exposes all slots to the parent for comparison.

Test Plan:
- LOAD_LAT=1, load writes r3, next instruction reads Rs=r3 -> one cycle controlZeroIdEx=1, writePc=writeIfId=0, then proceed.
- LOAD_LAT=2, same sequence -> two consecutive bubble cycles. With one independent instruction between -> one bubble. With two between -> none.
- LOAD_LAT=2, hazard pending, memBusy=1 for 3 cycles mid-stall -> pipeFreeze=1, controlZeroIdEx=0, writePc=0 for 3 cycles, then the remaining bubble is issued once.
- Load r5 followed by a consumer with flushIfId=1 -> no bubble, writePc=1. Also check that a non-load writing r5 (MemReadIdEx=0) never stalls.
- rst asserted during a LOAD_LAT=3 stall -> next cycle writePc=1, slots empty, counters 0.
- HAZARD_PERF_EN, CNT_W=4, 20 forced memBusy cycles -> memStallCycles saturates at 15.
